// File: rtl/io_int_controller.sv
// Peripheral partner of the processor I/O pins: presents external words on the
// input port with a timed interrupt pulse, and buffers OUT writes in a FIFO.
module io_int_controller #(
    parameter int DATA_W      = 16,
    parameter int OUT_DEPTH   = 4,
    parameter int INT_PULSE   = 2,
    parameter int INT_HOLDOFF = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            ext_in_data,
    input  logic                         ext_in_valid,
    output logic                         ext_in_ready,
    output logic [DATA_W-1:0]            cpu_in_port,
    output logic                         cpu_int,
    input  logic                         cpu_in_rd,
    input  logic [DATA_W-1:0]            cpu_out_port,
    input  logic                         cpu_out_we,
    output logic [DATA_W-1:0]            ext_out_data,
    output logic                         ext_out_valid,
    input  logic                         ext_out_ready,
    output logic [$clog2(OUT_DEPTH):0]   out_count,
    output logic                         out_overflow
);
    localparam int AW = $clog2(OUT_DEPTH);
    localparam int PW = $clog2(INT_PULSE + 1);
    localparam int HW = (INT_HOLDOFF > 0) ? $clog2(INT_HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_INT, S_WAIT_RD, S_HOLD} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pulse_cnt, pulse_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic            pending, pending_n;
    logic            latch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            pulse_cnt   <= '0;
            hold_cnt    <= '0;
            pending     <= 1'b0;
            cpu_in_port <= '0;
            cpu_int     <= 1'b0;
        end else begin
            state     <= state_n;
            pulse_cnt <= pulse_n;
            hold_cnt  <= hold_n;
            pending   <= pending_n;
            // Registered so the edge-sensitive interrupt input sees one clean rise per word.
            cpu_int   <= (state_n == S_INT);
            if (latch)
                cpu_in_port <= ext_in_data;
        end
    end

    always_comb begin
        state_n   = state;
        pulse_n   = pulse_cnt;
        hold_n    = hold_cnt;
        pending_n = pending;
        latch     = 1'b0;
        case (state)
            S_IDLE: begin
                if (ext_in_valid) begin
                    latch     = 1'b1;
                    pulse_n   = PW'(INT_PULSE);
                    pending_n = 1'b0;
                    state_n   = S_INT;
                end
            end
            S_INT: begin
                pulse_n = pulse_cnt - 1'b1;
                if (cpu_in_rd)
                    pending_n = 1'b1;
                if (pulse_cnt <= PW'(1)) begin
                    pending_n = 1'b0;
                    // A read that arrived during the pulse skips WAIT_RD entirely.
                    if (pending || cpu_in_rd) begin
                        if (INT_HOLDOFF > 0) begin
                            hold_n  = HW'(INT_HOLDOFF);
                            state_n = S_HOLD;
                        end else begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        state_n = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                if (cpu_in_rd) begin
                    if (INT_HOLDOFF > 0) begin
                        hold_n  = HW'(INT_HOLDOFF);
                        state_n = S_HOLD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                hold_n = hold_cnt - 1'b1;
                if (hold_cnt <= HW'(1))
                    state_n = S_IDLE;
            end
        endcase
    end

    assign ext_in_ready = (state == S_IDLE) && !reset;

    logic [DATA_W-1:0] mem [OUT_DEPTH];
    logic [AW:0]       wptr, rptr;
    logic              full, empty, push, pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && ext_out_ready;
    // Popping in the same cycle frees the slot, so a full FIFO still takes the write.
    assign push  = cpu_out_we && (!full || pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= cpu_out_port;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr         <= '0;
            rptr         <= '0;
            out_overflow <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (cpu_out_we && !push)
                out_overflow <= 1'b1;
        end
    end

    assign ext_out_data  = mem[rptr[AW-1:0]];
    assign ext_out_valid = !empty;
    assign out_count     = wptr - rptr;

endmodule

// File: tb/tb_io_int_controller.sv
// Bench for io_int_controller: directed scenarios plus random traffic, all
// checked against a timing-arithmetic model of the input path and a queue FIFO.
module tb_io_int_controller;
    localparam int DW = 16, D = 4, P = 2, H = 3;

    logic          clk = 1'b0, reset = 1'b0;
    logic [DW-1:0] ext_in_data = '0, cpu_out_port = '0;
    logic          ext_in_valid = 1'b0, cpu_in_rd = 1'b0, cpu_out_we = 1'b0, ext_out_ready = 1'b0;
    logic          ext_in_ready, cpu_int, ext_out_valid, out_overflow;
    logic [DW-1:0] cpu_in_port, ext_out_data;
    logic [2:0]    out_count;

    io_int_controller #(.DATA_W(DW), .OUT_DEPTH(D), .INT_PULSE(P), .INT_HOLDOFF(H)) dut (
        .clk(clk), .reset(reset),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .cpu_in_port(cpu_in_port), .cpu_int(cpu_int), .cpu_in_rd(cpu_in_rd),
        .cpu_out_port(cpu_out_port), .cpu_out_we(cpu_out_we),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .out_count(out_count), .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;

    // Model: a word accepted at edge t_acc raises the interrupt for P cycles; the
    // controller is free again H cycles after the later of pulse end and the read.
    int            cyc = 0, t_acc = -100, free_at = 0;
    bit            waiting = 0, m_ovf = 0;
    logic [DW-1:0] m_port = '0;
    logic [DW-1:0] q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        chk("ready", ext_in_ready, cyc >= free_at);
        chk("int", cpu_int, (cyc >= t_acc) && (cyc < t_acc + P));
        chk("port", cpu_in_port, m_port);
        chk("count", out_count, q.size());
        chk("oval", ext_out_valid, q.size() > 0);
        chk("ovf", out_overflow, m_ovf);
        if (q.size() > 0)
            chk("odata", ext_out_data, q[0]);
    endtask

    task automatic step();
        bit rdy_pre, pop;
        int sz;
        rdy_pre = (cyc >= free_at);
        sz      = q.size();
        pop     = (sz > 0) && ext_out_ready;
        @(posedge clk);
        cyc++;
        if (rdy_pre && ext_in_valid) begin
            t_acc   = cyc;
            m_port  = ext_in_data;
            waiting = 1;
            free_at = 1 << 30;
        end else if (waiting && cpu_in_rd) begin
            waiting = 0;
            free_at = ((t_acc + P > cyc) ? t_acc + P : cyc) + H;
        end
        if (pop)
            void'(q.pop_front());
        if (cpu_out_we) begin
            if (sz < D || pop) q.push_back(cpu_out_port);
            else m_ovf = 1;
        end
        #1;
        check_all();
    endtask

    task automatic model_reset();
        t_acc = -100; free_at = cyc; waiting = 0; m_ovf = 0; m_port = '0;
        q.delete();
    endtask

    task automatic release_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chk("rel_ready", ext_in_ready, 1);
    endtask

    task automatic check_reset_vals();
        chk("rst_int", cpu_int, 0);
        chk("rst_port", cpu_in_port, 0);
        chk("rst_ready", ext_in_ready, 0);
        chk("rst_count", out_count, 0);
        chk("rst_oval", ext_out_valid, 0);
        chk("rst_ovf", out_overflow, 0);
    endtask

    logic [DW-1:0] last_d;

    initial begin
        #2 reset = 1'b1;
        #1 check_reset_vals();
        model_reset();
        release_reset();

        // Single word: latch, 2-cycle pulse, then wait for IN.
        ext_in_data = 16'h1234; ext_in_valid = 1; step();
        chk("w1_port", cpu_in_port, 16'h1234);
        chk("w1_int", cpu_int, 1);
        ext_in_data = 16'hBEEF;
        for (int i = 0; i < 4; i++) step();
        cpu_in_rd = 1; step(); cpu_in_rd = 0;
        step(); step();
        chk("hold_ready0", ext_in_ready, 0);
        step();
        chk("hold_ready1", ext_in_ready, 1);
        step();
        ext_in_valid = 0;
        chk("w2_port", cpu_in_port, 16'hBEEF);
        chk("w2_int", cpu_int, 1);

        // Read during the second pulse cycle goes straight to HOLD.
        step();
        cpu_in_rd = 1; step(); cpu_in_rd = 0;
        chk("pend_int_end", cpu_int, 0);
        step(); step();
        chk("pend_ready0", ext_in_ready, 0);
        step();
        chk("pend_ready1", ext_in_ready, 1);

        // Full FIFO with simultaneous push and pop.
        cpu_out_we = 1;
        for (int i = 0; i < 4; i++) begin cpu_out_port = 16'h0010 + 16'(i); step(); end
        cpu_out_port = 16'h00AA; ext_out_ready = 1; step(); cpu_out_we = 0;
        chk("pp_count", out_count, 4);
        chk("pp_ovf", out_overflow, 0);
        for (int i = 0; i < 4; i++) begin last_d = ext_out_data; step(); end
        chk("pp_last", last_d, 16'h00AA);
        ext_out_ready = 0;

        // Overflow: fifth write dropped.
        cpu_out_we = 1;
        for (int i = 1; i <= 5; i++) begin cpu_out_port = 16'(i); step(); end
        cpu_out_we = 0;
        chk("of_count", out_count, 4);
        chk("of_ovf", out_overflow, 1);
        ext_out_ready = 1;
        for (int i = 1; i <= 4; i++) begin chk("of_drain", ext_out_data, 16'(i)); step(); end
        ext_out_ready = 0;

        // Reset mid-pulse with two words buffered.
        cpu_out_we = 1;
        for (int i = 0; i < 2; i++) begin cpu_out_port = 16'h0C00 + 16'(i); step(); end
        cpu_out_we = 0;
        ext_in_data = 16'h5A5A; ext_in_valid = 1; step(); ext_in_valid = 0;
        #2 reset = 1'b1;
        #1 check_reset_vals();
        model_reset();
        release_reset();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            ext_in_valid  = ($urandom_range(0, 2) != 0);
            ext_in_data   = DW'($urandom);
            cpu_in_rd     = ($urandom_range(0, 3) == 0);
            cpu_out_we    = ($urandom_range(0, 1) == 1);
            cpu_out_port  = DW'($urandom);
            ext_out_ready = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/io_int_controller.md
Name: io_int_controller

Overview:
Peripheral-side partner of the processor's I/O and interrupt pins. It accepts words from an external producer and presents them on the processor's input port, raising a timed interrupt pulse for each new word. It also captures every value the processor writes to its output port into a small FIFO, which an external consumer drains through a valid/ready handshake. It sits at top level, between the processor core and off-chip devices.

Parameters:
DATA_W, 16, width of the input and output port data.
OUT_DEPTH, 4, output FIFO depth in entries; power of two, minimum 2.
INT_PULSE, 2, number of cycles cpu_int is held high per event; minimum 1.
INT_HOLDOFF, 3, minimum idle cycles after a read before the next word is accepted; 0 is allowed.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-high.
ext_in_data  input  DATA_W  word from the external producer.
ext_in_valid  input  1  producer has a word.
ext_in_ready  output  1  controller can accept a word.
cpu_in_port  output  DATA_W  value presented to the processor input port.
cpu_int  output  1  interrupt request to the processor.
cpu_in_rd  input  1  one-cycle strobe: the processor executed IN.
cpu_out_port  input  DATA_W  processor output port value.
cpu_out_we  input  1  one-cycle strobe: the processor executed OUT.
ext_out_data  output  DATA_W  head of the output FIFO.
ext_out_valid  output  1  output FIFO is non-empty.
ext_out_ready  input  1  consumer accepts the head word.
out_count  output  clog2(OUT_DEPTH)+1  number of words in the output FIFO.
out_overflow  output  1  sticky flag: an OUT write was dropped because the FIFO was full.

Behaviour:
Reset (asynchronous, while reset=1):
- Input FSM goes to IDLE.
- cpu_in_port=0, cpu_int=0, ext_in_ready=0.
- FIFO pointers=0, out_count=0, ext_out_valid=0, out_overflow=0.
- The pulse and holdoff counters are cleared.
- Deasserting reset mid-transfer leaves no residue: the next accepted word starts a fresh sequence.

Input FSM, states IDLE, INT, WAIT_RD, HOLD:
- IDLE: ext_in_ready=1. On ext_in_valid=1:
  - latch ext_in_data into cpu_in_port;
  - load the pulse counter with INT_PULSE;
  - next state INT.
- INT: cpu_int=1 and ext_in_ready=0. The counter decrements each cycle. After INT_PULSE cycles in INT, the next state is WAIT_RD, or HOLD if a read is already pending.
- A cpu_in_rd seen during INT is recorded in a pending flag; cpu_int still completes its full pulse.
- WAIT_RD: cpu_int=0 and ext_in_ready=0. On cpu_in_rd:
  - if INT_HOLDOFF>0, load the holdoff counter and go to HOLD;
  - if INT_HOLDOFF=0, go to IDLE.
- HOLD: counts INT_HOLDOFF cycles, then goes to IDLE.
- cpu_in_rd in IDLE or HOLD is ignored.
- cpu_in_port holds its value until the next word is accepted; it is never cleared by a read.
- cpu_int is a registered output, so its edge is glitch-free. The processor's interrupt input is edge-sensitive, so each accepted word produces exactly one rising edge.
- Latency: word accepted at edge N → cpu_in_port valid and cpu_int high from N+1 through N+INT_PULSE.

Output FIFO:
- Push on cpu_out_we: writes cpu_out_port at the write pointer. Pop on ext_out_valid & ext_out_ready.
- First-word-fall-through: ext_out_data is the head entry. A push into an empty FIFO is visible one cycle later.
- Pointers are clog2(OUT_DEPTH)+1 bits wide and wrap modulo 2*OUT_DEPTH. Full when the low bits match and the MSBs differ.
- Push while full with no pop in the same cycle: the word is dropped and out_overflow sets (sticky until reset). FIFO contents are unchanged.
- Push and pop in the same cycle when full: both happen, the count is unchanged, and out_overflow is not set.
- Push and pop in the same cycle when empty: only the push happens, because ext_out_valid is 0.
- ext_out_data is undefined-but-stable when empty: it reads the stale entry, and the bench must not check it.

Test Plan:
- Reset, then ext_in_data=0x1234 with valid=1 for one cycle → cpu_in_port=0x1234 next cycle; cpu_int high for exactly 2 cycles; ext_in_ready=0 until cpu_in_rd.
- After word 0x1234, hold ext_in_valid=1 with 0xBEEF; strobe cpu_in_rd 5 cycles after acceptance → ext_in_ready returns exactly 3 cycles after the strobe; 0xBEEF is latched; a second single cpu_int pulse follows.
- cpu_in_rd asserted during the second cycle of the INT pulse → pulse completes (2 cycles); FSM goes directly to HOLD; IDLE is reached 3 cycles later without another read.
- Five OUT writes 0x0001..0x0005 with ext_out_ready=0 → out_count=4, out_overflow=1, drain order 0x0001..0x0004.
- FIFO full and ext_out_ready=1 while cpu_out_we writes 0x00AA → out_count stays 4, out_overflow stays 0, 0x00AA is the last word drained.
- Assert reset mid-INT pulse with the FIFO holding 2 words → cpu_int=0, cpu_in_port=0, out_count=0, ext_out_valid=0 immediately; after release, ext_in_ready=1 on the first cycle.
